// File: rtl/window_packer_pkg.sv
// Shared sizing helpers for the window packer and the adder tree it feeds.
// Both sides take the packed width and the sum width from here.
package window_packer_pkg;

  typedef enum logic {
    MODE_BLOCK = 1'b0,
    MODE_SLIDE = 1'b1
  } mode_e;

  function automatic int window_width(input int depth, input int len);
    return depth * len;
  endfunction

  // Same formula as the adder tree: one extra bit per halving level.
  function automatic int sum_width(input int depth, input int len);
    return depth + $clog2(len);
  endfunction

endpackage

// File: rtl/pack_out_stage.sv
// One-entry valid/ready output register holding the packed window and its
// frame-end flag.
module pack_out_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] dout,
  output logic         out_last
);

  logic         valid_reg;
  logic [W-1:0] data_reg;
  logic         last_reg;

  // A load while the held window is being consumed simply replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (en) begin
      if (load) begin
        valid_reg <= 1'b1;
        data_reg  <= load_data;
        last_reg  <= load_last;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = valid_reg;
  assign dout      = data_reg;
  assign out_last  = last_reg;

endmodule

// File: rtl/window_packer.sv
// Serial-to-parallel front end for the adder tree: packs ArrL samples into
// one vector (sample 0 = oldest in the low bits), block or sliding windows.
module window_packer
  import window_packer_pkg::*;
#(
  parameter int data_depth = 8,
  parameter int ArrL       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [data_depth-1:0]      in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [data_depth*ArrL-1:0] DOut,
  output logic                       out_last
);

  localparam int W  = window_width(data_depth, ArrL);
  localparam int CW = $clog2(ArrL + 1);

  logic [data_depth-1:0] slot_reg  [ArrL];
  logic [data_depth-1:0] slot_next [ArrL];
  logic [data_depth-1:0] blk_slot  [ArrL];
  logic [data_depth-1:0] sld_slot  [ArrL];
  logic [CW-1:0]         cnt_reg, cnt_next;
  mode_e                 mode_q_reg, mode_q_next;

  logic         accept;
  logic         frame_start;
  logic         slide_mode;
  logic         emit;
  logic         clear;
  logic [W-1:0] win_next;

  assign in_ready = en && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Block mode writes in place; sliding mode shifts toward slot 0.
  for (genvar gi = 0; gi < ArrL; gi++) begin : g_slot
    assign blk_slot[gi] = (cnt_reg == CW'(gi)) ? in_data : slot_reg[gi];
    if (gi == ArrL - 1) begin : g_tail
      assign sld_slot[gi] = in_data;
    end else begin : g_body
      assign sld_slot[gi] = slot_reg[gi+1];
    end
    assign win_next[gi*data_depth +: data_depth] = slide_mode ? sld_slot[gi] : blk_slot[gi];
  end

  always_comb begin
    frame_start = (cnt_reg == '0);
    slide_mode  = frame_start ? mode : (mode_q_reg == MODE_SLIDE);
    mode_q_next = frame_start ? mode_e'(mode) : mode_q_reg;

    if (slide_mode) begin
      emit  = (cnt_reg >= CW'(ArrL - 1));
      clear = in_last;
    end else begin
      emit  = (cnt_reg == CW'(ArrL - 1)) || in_last;
      clear = emit;
    end

    if (clear) begin
      cnt_next = '0;
    end else if (slide_mode && cnt_reg == CW'(ArrL)) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end

    for (int i = 0; i < ArrL; i++) begin
      slot_next[i] = '0;
      if (!clear) begin
        slot_next[i] = slide_mode ? sld_slot[i] : blk_slot[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      mode_q_reg <= MODE_BLOCK;
      for (int i = 0; i < ArrL; i++) begin
        slot_reg[i] <= '0;
      end
    end else if (accept) begin
      cnt_reg    <= cnt_next;
      mode_q_reg <= mode_q_next;
      for (int i = 0; i < ArrL; i++) begin
        slot_reg[i] <= slot_next[i];
      end
    end
  end

  pack_out_stage #(
    .W(W)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (accept && emit),
    .load_data (win_next),
    .load_last (in_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dout      (DOut),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_window_packer.sv
// Directed vector table for the documented scenarios, then a randomized run
// against a queue-based reference model of the window rules.
module tb_window_packer;

  localparam int DD = 8;
  localparam int AL = 4;

  logic            clk = 1'b0;
  logic            rst, en, mode, in_valid, in_last, out_ready;
  logic [DD-1:0]   in_data;
  logic            in_ready, out_valid, out_last;
  logic [DD*AL-1:0] DOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  window_packer #(.data_depth(DD), .ArrL(AL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .DOut(DOut), .out_last(out_last)
  );

  typedef struct {
    logic        rst, en, mode, vld;
    logic [7:0]  d;
    logic        last, ordy;
    logic        er, eov;
    logic [31:0] edout;
    logic        elast;
  } vec_t;

  vec_t tbl[$];

  function automatic void r(input logic rs, e, m, v, input logic [7:0] d, input logic l, o,
                            input logic er, eov, input logic [31:0] ed, input logic el);
    vec_t x;
    x.rst = rs; x.en = e; x.mode = m; x.vld = v; x.d = d; x.last = l; x.ordy = o;
    x.er = er; x.eov = eov; x.edout = ed; x.elast = el;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rs, e, m, v, input logic [7:0] d, input logic l, o);
    rst = rs; en = e; mode = m; in_valid = v; in_data = d; in_last = l; out_ready = o;
    #1;
  endtask

  // Reference model: the current frame's samples in arrival order.
  logic [7:0]  q[$];
  logic        m_mode, m_ov, m_last;
  logic [31:0] m_dout;

  function automatic logic [31:0] pack_q();
    logic [31:0] w = '0;
    for (int k = 0; k < AL; k++) w[k*8 +: 8] = (k < q.size()) ? q[k] : 8'h00;
    return w;
  endfunction

  function automatic void model(input logic rs, e, m, v, input logic [7:0] d, input logic l, o);
    logic        acc, load;
    logic [31:0] w;
    if (rs) begin
      q.delete(); m_mode = 0; m_ov = 0; m_dout = '0; m_last = 0;
    end else if (e) begin
      acc = v && (!m_ov || o);
      load = 0;
      w = '0;
      if (acc) begin
        if (q.size() == 0) m_mode = m;
        q.push_back(d);
        if (!m_mode) begin
          if (q.size() == AL || l) begin load = 1; w = pack_q(); q.delete(); end
        end else begin
          if (q.size() > AL) void'(q.pop_front());
          if (q.size() == AL) begin load = 1; w = pack_q(); end
          if (l) q.delete();
        end
      end
      if (load) begin m_ov = 1; m_dout = w; m_last = l; end
      else if (m_ov && o) m_ov = 0;
    end
  endfunction

  initial begin
    drive(1, 1, 0, 0, 8'h00, 0, 1);
    repeat (2) @(posedge clk);
    #1;

    // reset state
    r(1,1,0,0,8'h00,0,1, 1,0,32'h0,0);
    // block 01..04
    r(0,1,0,1,8'h01,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h02,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h03,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h04,0,1, 1,1,32'h04030201,0);
    r(0,1,0,0,8'h00,0,1, 1,0,32'h0,0);
    // sliding 01..06
    r(0,1,1,1,8'h01,0,1, 1,0,32'h0,0);
    r(0,1,1,1,8'h02,0,1, 1,0,32'h0,0);
    r(0,1,1,1,8'h03,0,1, 1,0,32'h0,0);
    r(0,1,1,1,8'h04,0,1, 1,1,32'h04030201,0);
    r(0,1,1,1,8'h05,0,1, 1,1,32'h05040302,0);
    r(0,1,1,1,8'h06,1,1, 1,1,32'h06050403,1);
    r(0,1,0,0,8'h00,0,1, 1,0,32'h0,0);
    // block short frame then full frame
    r(0,1,0,1,8'h01,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h02,1,1, 1,1,32'h00000201,1);
    r(0,1,0,1,8'h05,0,1, 1,0,32'h0,0);
    r(0,1,1,1,8'h06,0,1, 1,0,32'h0,0);
    r(0,1,1,1,8'h07,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h08,0,1, 1,1,32'h08070605,0);
    r(0,1,0,0,8'h00,0,1, 1,0,32'h0,0);
    // sliding short frame emits nothing; next frame emits once
    r(0,1,1,1,8'h01,0,1, 1,0,32'h0,0);
    r(0,1,1,1,8'h02,1,1, 1,0,32'h0,0);
    r(0,1,1,1,8'h11,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h12,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h13,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h14,1,1, 1,1,32'h14131211,1);
    r(0,1,0,0,8'h00,0,1, 1,0,32'h0,0);
    // backpressure
    r(0,1,0,1,8'h21,0,0, 1,0,32'h0,0);
    r(0,1,0,1,8'h22,0,0, 1,0,32'h0,0);
    r(0,1,0,1,8'h23,0,0, 1,0,32'h0,0);
    r(0,1,0,1,8'h24,0,0, 1,1,32'h24232221,0);
    for (int i = 0; i < 5; i++) r(0,1,0,1,8'h31,0,0, 0,1,32'h24232221,0);
    r(0,1,0,1,8'h31,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h32,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h33,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h34,0,1, 1,1,32'h34333231,0);
    r(0,1,0,0,8'h00,0,1, 1,0,32'h0,0);
    // reset mid-window, then enable gaps mid-window
    r(0,1,0,1,8'h41,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h42,0,1, 1,0,32'h0,0);
    r(1,1,0,1,8'h99,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h09,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h0A,0,1, 1,0,32'h0,0);
    for (int i = 0; i < 3; i++) r(0,0,1,1,8'h55,1,1, 0,0,32'h0,0);
    r(0,1,0,1,8'h0B,0,1, 1,0,32'h0,0);
    r(0,1,0,1,8'h0C,0,1, 1,1,32'h0C0B0A09,0);
    r(0,0,0,0,8'h00,0,1, 0,1,32'h0C0B0A09,0);
    r(0,0,0,1,8'h77,1,1, 0,1,32'h0C0B0A09,0);
    r(0,1,0,0,8'h00,0,1, 1,0,32'h0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].vld, tbl[i].d, tbl[i].last, tbl[i].ordy);
      chk($sformatf("row%0d in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].er});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].eov});
      if (tbl[i].eov || tbl[i].rst) begin
        chk($sformatf("row%0d DOut", i), DOut, tbl[i].edout);
        chk($sformatf("row%0d out_last", i), {31'b0, out_last}, {31'b0, tbl[i].elast});
        $display("row %0d: window %h last %b", i, DOut, out_last);
      end
    end

    // Randomized run against the reference model.
    drive(1, 1, 0, 0, 8'h00, 0, 1);
    model(1, 1, 0, 0, 8'h00, 0, 1);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      logic rs, e, m, v, l, o;
      logic [7:0] d;
      rs = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) != 0);
      m  = $urandom_range(0, 1) != 0;
      v  = ($urandom_range(0, 9) < 7);
      l  = ($urandom_range(0, 99) < 15);
      o  = ($urandom_range(0, 9) < 7);
      d  = 8'($urandom);
      drive(rs, e, m, v, d, l, o);
      chk($sformatf("rnd%0d in_ready", c), {31'b0, in_ready}, {31'b0, (e && (!m_ov || o))});
      model(rs, e, m, v, d, l, o);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d out_valid", c), {31'b0, out_valid}, {31'b0, m_ov});
      if (m_ov) begin
        chk($sformatf("rnd%0d DOut", c), DOut, m_dout);
        chk($sformatf("rnd%0d out_last", c), {31'b0, out_last}, {31'b0, m_last});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
